exe_stage_mul: RTL and testbench

Parametrised execute stage for the ARM pipeline. It computes ALU operands with ID/MEM/WB forwarding and drives the shared ALU and Val_Two_Generator. It adds an iterative multiplier for MUL/MLA, which stalls upstream while it runs, and registers all EX/MEM outputs internally with valid, stall and flush control.

---
 rtl/exe_stage_mul.sv | 212 +++++++++++++++++++++
 tb/tb_exe_stage_mul.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_mul.sv
// exe_stage_mul: ARM execute stage with operand forwarding, ALU, shifter and an iterative MUL/MLA unit.
// Inputs : clk, rst (async, active high), in_valid, stall_in, flush, ID/EX control and operand fields,
//          forwarding selects sel_src1/sel_src2 with mem_wb_value/wb_wb_value.
// Outputs: busy (combinational upstream hold), registered EX/MEM fields out_valid, PC, alu_res,
//          val_rm_out, branch_address, wb_en_out, mem_r_en_out, mem_w_en_out, alu_status {N,Z,C,V}, dest_out.
module exe_stage_mul #(
    parameter int MUL_STEP   = 2,
    parameter int BR_IMM_W   = 24,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic [31:0]           PC_in,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic                  wb_en,
    input  logic                  imm,
    input  logic                  carry_in,
    input  logic                  is_mul,
    input  logic                  accumulate,
    input  logic [11:0]           shift_operand,
    input  logic [3:0]            exec_cmd,
    input  logic [31:0]           val_rn,
    input  logic [31:0]           val_rm,
    input  logic [31:0]           val_acc,
    input  logic [BR_IMM_W-1:0]   signed_immed,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic [1:0]            sel_src1,
    input  logic [1:0]            sel_src2,
    input  logic [31:0]           mem_wb_value,
    input  logic [31:0]           wb_wb_value,
    output logic                  busy,
    output logic                  out_valid,
    output logic [31:0]           PC,
    output logic [31:0]           alu_res,
    output logic [31:0]           val_rm_out,
    output logic [31:0]           branch_address,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic [3:0]            alu_status,
    output logic [REG_ADDR_W-1:0] dest_out
);
    localparam int N  = 32 / MUL_STEP;
    localparam int CW = $clog2(N);
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [3:0] ALU_MOV = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_ADC = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SBC = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_ORR = 4'b0111;
    localparam logic [3:0] ALU_EOR = 4'b1000;
    localparam logic [3:0] ALU_MVN = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_count;
    logic [31:0]           r_mcand;
    logic [31:0]           r_mplier;
    logic [31:0]           r_prod;
    logic [31:0]           r_acc;
    logic [31:0]           r_pc;
    logic [REG_ADDR_W-1:0] r_dest;
    logic                  r_wb;
    logic                  r_carry;

    logic [31:0] w_op1, w_op2, w_val2, w_shifted, w_asr;
    logic [63:0] w_imm_rr, w_rm_rr;
    logic [32:0] w_alu_sum;
    logic [31:0] w_alu_res, w_br, w_partial, w_mul_res;
    logic [3:0]  w_status;
    logic        w_c, w_v, w_start;

    assign w_op1 = sel_src1 == FWD_MEM ? mem_wb_value : sel_src1 == FWD_WB ? wb_wb_value : val_rn;
    assign w_op2 = sel_src2 == FWD_MEM ? mem_wb_value : sel_src2 == FWD_WB ? wb_wb_value : val_rm;

    // Immediate: 8-bit value rotated right by twice the 4-bit rotate field; rotations use a doubled word.
    assign w_imm_rr  = {24'b0, shift_operand[7:0], 24'b0, shift_operand[7:0]} >> {shift_operand[11:8], 1'b0};
    assign w_rm_rr   = {w_op2, w_op2} >> shift_operand[11:7];
    // Kept in its own assignment so the arithmetic shift stays signed.
    assign w_asr     = $signed(w_op2) >>> shift_operand[11:7];
    assign w_shifted = shift_operand[6:5] == 2'b00 ? w_op2 << shift_operand[11:7] :
                       shift_operand[6:5] == 2'b01 ? w_op2 >> shift_operand[11:7] :
                       shift_operand[6:5] == 2'b10 ? w_asr : w_rm_rr[31:0];
    // Loads/stores use the raw 12-bit offset, zero extended.
    assign w_val2    = (mem_r_en | mem_w_en) ? {20'b0, shift_operand} : imm ? w_imm_rr[31:0] : w_shifted;

    always_comb begin
        w_alu_sum = '0;
        w_alu_res = '0;
        w_c       = carry_in;
        w_v       = 1'b0;
        case (exec_cmd)
            ALU_MOV: w_alu_res = w_val2;
            ALU_MVN: w_alu_res = ~w_val2;
            ALU_AND: w_alu_res = w_op1 & w_val2;
            ALU_ORR: w_alu_res = w_op1 | w_val2;
            ALU_EOR: w_alu_res = w_op1 ^ w_val2;
            ALU_ADD, ALU_ADC: begin
                w_alu_sum = {1'b0, w_op1} + {1'b0, w_val2} + {32'b0, (exec_cmd == ALU_ADC) & carry_in};
                w_alu_res = w_alu_sum[31:0];
                w_c       = w_alu_sum[32];
                w_v       = (w_op1[31] == w_val2[31]) && (w_alu_sum[31] != w_op1[31]);
            end
            ALU_SUB, ALU_SBC: begin
                // Subtract as a + ~b + 1 (SBC uses carry_in), so C means "no borrow".
                w_alu_sum = {1'b0, w_op1} + {1'b0, ~w_val2} + {32'b0, (exec_cmd == ALU_SUB) | carry_in};
                w_alu_res = w_alu_sum[31:0];
                w_c       = w_alu_sum[32];
                w_v       = (w_op1[31] != w_val2[31]) && (w_alu_sum[31] != w_op1[31]);
            end
            default: w_alu_res = '0;
        endcase
    end

    assign w_status = {w_alu_res[31], w_alu_res == 32'b0, w_c, w_v};
    assign w_br     = PC_in + {{(30 - BR_IMM_W){signed_immed[BR_IMM_W-1]}}, signed_immed, 2'b00};

    // The multiplicand is pre-shifted each iteration, equivalent to shifting the partial by count*MUL_STEP.
    assign w_partial = r_mcand * {{(32 - MUL_STEP){1'b0}}, r_mplier[MUL_STEP-1:0]};
    assign w_mul_res = r_prod + r_acc;

    assign w_start = r_state == S_IDLE && in_valid && is_mul && !flush;
    assign busy    = w_start || r_state == S_MUL || (r_state == S_DONE && stall_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_prod         <= '0;
            r_acc          <= '0;
            r_pc           <= '0;
            r_dest         <= '0;
            r_wb           <= 1'b0;
            r_carry        <= 1'b0;
            out_valid      <= 1'b0;
            PC             <= '0;
            alu_res        <= '0;
            val_rm_out     <= '0;
            branch_address <= '0;
            wb_en_out      <= 1'b0;
            mem_r_en_out   <= 1'b0;
            mem_w_en_out   <= 1'b0;
            alu_status     <= '0;
            dest_out       <= '0;
        end else if (flush) begin
            r_state   <= S_IDLE;
            r_prod    <= '0;
            r_count   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mcand  <= w_op1;
                        r_mplier <= w_op2;
                        r_acc    <= accumulate ? val_acc : 32'b0;
                        r_dest   <= dest;
                        r_wb     <= wb_en;
                        r_pc     <= PC_in;
                        r_carry  <= carry_in;
                        r_prod   <= '0;
                        r_count  <= '0;
                        r_state  <= S_MUL;
                        if (!stall_in) out_valid <= 1'b0;
                    end else if (!stall_in) begin
                        out_valid      <= in_valid;
                        PC             <= PC_in;
                        alu_res        <= w_alu_res;
                        val_rm_out     <= w_op2;
                        branch_address <= w_br;
                        wb_en_out      <= wb_en;
                        mem_r_en_out   <= mem_r_en;
                        mem_w_en_out   <= mem_w_en;
                        alu_status     <= w_status;
                        dest_out       <= dest;
                    end
                end
                S_MUL: begin
                    r_prod   <= r_prod + w_partial;
                    r_mcand  <= r_mcand << MUL_STEP;
                    r_mplier <= r_mplier >> MUL_STEP;
                    r_count  <= r_count + 1'b1;
                    if (r_count == CW'(N - 1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!stall_in) begin
                        out_valid    <= 1'b1;
                        PC           <= r_pc;
                        alu_res      <= w_mul_res;
                        wb_en_out    <= r_wb;
                        mem_r_en_out <= 1'b0;
                        mem_w_en_out <= 1'b0;
                        alu_status   <= {w_mul_res[31], w_mul_res == 32'b0, r_carry, 1'b0};
                        dest_out     <= r_dest;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_stage_mul.sv
// tb_exe_stage_mul: directed scoreboard bench for exe_stage_mul (ALU path, forwarding, MUL/MLA, flush, stall, reset).
module tb_exe_stage_mul;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall_in, flush, mem_r_en, mem_w_en, wb_en, imm, carry_in, is_mul, accumulate;
    logic [31:0] PC_in, val_rn, val_rm, val_acc, mem_wb_value, wb_wb_value;
    logic [11:0] shift_operand;
    logic [3:0]  exec_cmd, dest;
    logic [23:0] signed_immed;
    logic [1:0]  sel_src1, sel_src2;
    logic        busy, out_valid, wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [31:0] PC, alu_res, val_rm_out, branch_address;
    logic [3:0]  alu_status, dest_out;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  st;
        logic        chk_st;
        logic [3:0]  dst;
        logic        wb;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int bc, lat;
    logic ov1;

    exe_stage_mul #(.MUL_STEP(2), .BR_IMM_W(24), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
        .PC_in(PC_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .imm(imm),
        .carry_in(carry_in), .is_mul(is_mul), .accumulate(accumulate), .shift_operand(shift_operand),
        .exec_cmd(exec_cmd), .val_rn(val_rn), .val_rm(val_rm), .val_acc(val_acc),
        .signed_immed(signed_immed), .dest(dest), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_wb_value(mem_wb_value), .wb_wb_value(wb_wb_value), .busy(busy), .out_valid(out_valid),
        .PC(PC), .alu_res(alu_res), .val_rm_out(val_rm_out), .branch_address(branch_address),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .alu_status(alu_status), .dest_out(dest_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; stall_in = 0; flush = 0; mem_r_en = 0; mem_w_en = 0; wb_en = 0; imm = 0;
        carry_in = 0; is_mul = 0; accumulate = 0; PC_in = 0; val_rn = 0; val_rm = 0; val_acc = 0;
        mem_wb_value = 0; wb_wb_value = 0; shift_operand = 0; exec_cmd = 0; dest = 0;
        signed_immed = 0; sel_src1 = 0; sel_src2 = 0;
    endtask

    task automatic push(input logic [31:0] res, input logic [3:0] st, input logic chk_st,
                        input logic [3:0] dst, input logic wb);
        exp_t e;
        e.res = res; e.st = st; e.chk_st = chk_st; e.dst = dst; e.wb = wb;
        sb.push_back(e);
    endtask

    // Holds the instruction until busy is low at a clock edge, then drops it; counts busy cycles and edges.
    task automatic issue(output int b, output int l, output logic v1);
        logic done;
        done = 0; b = 0; l = 0; v1 = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (busy) b++;
            done = !busy;
            @(posedge clk);
            l++;
            #1;
            if (l == 1) v1 = out_valid;
        end
        chk("issue_consumed", 32'(done), 32'd1);
        idle_inputs();
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_res"}, alu_res, e.res);
            if (e.chk_st) chk({tag, "_status"}, 32'(alu_status), 32'(e.st));
            chk({tag, "_dest"}, 32'(dest_out), 32'(e.dst));
            chk({tag, "_wb"}, 32'(wb_en_out), 32'(e.wb));
        end
    endtask

    initial begin
        logic [31:0] a, b2, c;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_res", alu_res, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pc", PC, 0);
        chk("rst_status", 32'(alu_status), 0);
        @(negedge clk);
        rst = 0;

        // ADD with op1 forwarded from MEM: 10 + 3
        @(negedge clk);
        in_valid = 1; exec_cmd = 4'b0010; val_rn = 5; val_rm = 3; sel_src1 = 2'b01; mem_wb_value = 10;
        wb_en = 1; dest = 4'd3;
        push(32'd13, 4'b0000, 1, 4'd3, 1);
        issue(bc, lat, ov1);
        check_out("add");
        chk("add_busy_cycles", bc, 0);
        chk("add_latency", lat, 1);

        // SUB with op2 forwarded from WB: 50 - 20
        @(negedge clk);
        in_valid = 1; exec_cmd = 4'b0100; val_rn = 50; val_rm = 999; sel_src2 = 2'b10; wb_wb_value = 20;
        wb_en = 1; dest = 4'd4;
        push(32'd30, 4'b0000, 0, 4'd4, 1);
        issue(bc, lat, ov1);
        check_out("sub_fwd_wb");

        // MOV immediate: 0xFF rotated right by 8
        @(negedge clk);
        in_valid = 1; exec_cmd = 4'b0001; imm = 1; shift_operand = 12'h4FF; dest = 4'd1;
        push(32'hFF00_0000, 4'b0000, 0, 4'd1, 0);
        issue(bc, lat, ov1);
        check_out("mov_imm");
        chk("mov_imm_n", 32'(alu_status[3]), 1);

        // MOV register LSL #4: 3 << 4
        @(negedge clk);
        in_valid = 1; exec_cmd = 4'b0001; val_rm = 3; shift_operand = 12'h200; dest = 4'd2; wb_en = 1;
        push(32'h30, 4'b0000, 0, 4'd2, 1);
        issue(bc, lat, ov1);
        check_out("mov_lsl");

        // LDR address: base + 12-bit offset
        @(negedge clk);
        in_valid = 1; exec_cmd = 4'b0010; mem_r_en = 1; val_rn = 32'h1000; shift_operand = 12'h804;
        dest = 4'd6; wb_en = 1;
        push(32'h1804, 4'b0000, 0, 4'd6, 1);
        issue(bc, lat, ov1);
        check_out("ldr_addr");
        chk("ldr_mem_r_en", 32'(mem_r_en_out), 1);

        // stall_in in IDLE: EX/MEM holds the LDR result while a new ADD waits
        stall_in = 1; in_valid = 1; exec_cmd = 4'b0010; val_rn = 1; val_rm = 1; dest = 4'd7;
        @(posedge clk);
        #1;
        chk("stall_hold_res", alu_res, 32'h1804);
        chk("stall_hold_valid", 32'(out_valid), 1);
        chk("stall_hold_mem_r", 32'(mem_r_en_out), 1);
        stall_in = 0;
        push(32'd2, 4'b0000, 1, 4'd7, 0);
        issue(bc, lat, ov1);
        check_out("after_stall_add");

        // Branch target: 0x100 + (-2 << 2)
        @(negedge clk);
        in_valid = 1; PC_in = 32'h100; signed_immed = 24'hFF_FFFE;
        issue(bc, lat, ov1);
        chk("branch_addr", branch_address, 32'hF8);
        chk("branch_pc", PC, 32'h100);

        // MUL 7 * 6
        @(negedge clk);
        in_valid = 1; is_mul = 1; val_rn = 7; val_rm = 6; dest = 4'd5; wb_en = 1;
        push(32'd42, 4'b0000, 1, 4'd5, 1);
        issue(bc, lat, ov1);
        check_out("mul_7x6");
        chk("mul_busy_cycles", bc, N + 1);
        chk("mul_latency", lat, N + 2);
        chk("mul_bubble", 32'(ov1), 0);
        chk("mul_mem_r_en", 32'(mem_r_en_out), 0);

        // MLA 0xFFFFFFFF * 2 + 5 with carry_in latched into C
        a = 32'hFFFF_FFFF; b2 = 32'd2; c = 32'd5;
        @(negedge clk);
        in_valid = 1; is_mul = 1; accumulate = 1; val_rn = a; val_rm = b2; val_acc = c; carry_in = 1;
        dest = 4'd8; wb_en = 1;
        push(a * b2 + c, 4'b0010, 1, 4'd8, 1);
        issue(bc, lat, ov1);
        check_out("mla_wrap");

        // MLA 0 * 9 + 0 gives zero flag
        @(negedge clk);
        in_valid = 1; is_mul = 1; accumulate = 1; val_rn = 0; val_rm = 9; val_acc = 0; dest = 4'd9;
        push(32'd0, 4'b0100, 1, 4'd9, 0);
        issue(bc, lat, ov1);
        check_out("mla_zero");

        // MUL with val_acc present but accumulate low: addend ignored
        @(negedge clk);
        in_valid = 1; is_mul = 1; val_rn = 32'h1234; val_rm = 32'h10; val_acc = 32'h77; dest = 4'd10;
        push(32'h12340, 4'b0000, 1, 4'd10, 0);
        issue(bc, lat, ov1);
        check_out("mul_no_acc");

        // flush during iteration 5 aborts the multiply
        @(negedge clk);
        in_valid = 1; is_mul = 1; val_rn = 3; val_rm = 4; dest = 4'd11;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        idle_inputs();
        flush = 1;
        @(posedge clk);
        #1;
        flush = 0;
        #1;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_valid", 32'(out_valid), 0);
        @(negedge clk);
        in_valid = 1; exec_cmd = 4'b0010; val_rn = 2; val_rm = 2; dest = 4'd12;
        push(32'd4, 4'b0000, 1, 4'd12, 0);
        issue(bc, lat, ov1);
        check_out("add_after_flush");
        chk("add_after_flush_lat", lat, 1);

        // stall_in held 3 cycles while in DONE
        @(negedge clk);
        in_valid = 1; is_mul = 1; val_rn = 9; val_rm = 9; dest = 4'd13; wb_en = 1;
        push(32'd81, 4'b0000, 1, 4'd13, 1);
        @(posedge clk);
        repeat (N) @(posedge clk);
        #1;
        stall_in = 1;
        #1;
        chk("done_stall_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("done_stall_held", 32'(out_valid), 0);
        end
        stall_in = 0;
        #1;
        chk("done_release_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        idle_inputs();
        check_out("mul_after_stall");

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1; is_mul = 1; val_rn = 5; val_rm = 5; dest = 4'd14;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        idle_inputs();
        rst = 1;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_res", alu_res, 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_dest", 32'(dest_out), 0);
        chk("rst_mid_wb", 32'(wb_en_out), 0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
